// File: rtl/mm_host_pkg.sv
// Shared types and sizing helpers for the matrix_multiplier host sequencer.
package mm_host_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DRAIN  = 3'd4
  } mm_state_t;

  function automatic int elem_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Index width must hold the largest of the three element counts.
  function automatic int count_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mm_stream_counter.sv
// Element index counter with enable, terminal-count flag and wrap to zero.
module mm_stream_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mm_host_sequencer.sv
// Streams A/B into matrix_multiplier operand buses and replays C as a stream.
// Optional out_last port is enabled by defining MM_HOST_LAST_EN.
module mm_host_sequencer
  import mm_host_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int P          = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         busy,
  output logic                         mm_start,
  input  logic                         mm_done,
  output logic [M*N*DATA_WIDTH-1:0]    mm_matrix_a,
  output logic [N*P*DATA_WIDTH-1:0]    mm_matrix_b,
  input  logic [M*P*DATA_WIDTH-1:0]    mm_result_c
`ifdef MM_HOST_LAST_EN
  ,
  output logic                         out_last
`endif
);

  localparam int A_COUNT = elem_count(M, N);
  localparam int B_COUNT = elem_count(N, P);
  localparam int C_COUNT = elem_count(M, P);
  localparam int CW      = count_width(A_COUNT, B_COUNT, C_COUNT);

  localparam logic [CW-1:0] A_LAST = CW'(A_COUNT - 1);
  localparam logic [CW-1:0] B_LAST = CW'(B_COUNT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(C_COUNT - 1);

  mm_state_t state, state_next;

  logic [CW-1:0] idx;
  logic [CW-1:0] idx_last;
  logic          idx_en;
  logic          idx_tc;
  int            slot_lsb;

  logic [M*N*DATA_WIDTH-1:0] a_reg;
  logic [N*P*DATA_WIDTH-1:0] b_reg;
  logic [M*P*DATA_WIDTH-1:0] c_reg;

  // One index serves the A load, the B load and the C drain in turn.
  mm_stream_counter #(
    .WIDTH (CW)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .en    (idx_en),
    .last  (idx_last),
    .count (idx),
    .tc    (idx_tc)
  );

  assign slot_lsb = int'(idx) * DATA_WIDTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_en     = 1'b0;
    idx_last   = A_LAST;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mm_start   = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        idx_en   = in_valid;
        idx_last = A_LAST;
        if (in_valid && idx_tc) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        idx_en   = in_valid;
        idx_last = B_LAST;
        if (in_valid && idx_tc) state_next = START;
      end
      START: begin
        mm_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (mm_done) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        idx_en    = out_ready;
        idx_last  = C_LAST;
        if (out_ready && idx_tc) state_next = LOAD_A;
      end
      default: state_next = LOAD_A;
    endcase
  end

  // Operands only change on accepted loads, so they stay put through START/WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
    end else begin
      if (state == LOAD_A && in_valid) a_reg[slot_lsb +: DATA_WIDTH] <= in_data;
      if (state == LOAD_B && in_valid) b_reg[slot_lsb +: DATA_WIDTH] <= in_data;
      if (state == WAIT && mm_done)    c_reg <= mm_result_c;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == DRAIN) out_data = c_reg[slot_lsb +: DATA_WIDTH];
  end

  assign mm_matrix_a = a_reg;
  assign mm_matrix_b = b_reg;
  assign busy        = !(state == LOAD_A && idx == '0);

`ifdef MM_HOST_LAST_EN
  assign out_last = out_valid && (idx == C_LAST);
`endif

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Scoreboard bench for mm_host_sequencer with a behavioural matrix_multiplier.
module tb_mm_host_sequencer;

  localparam int DW  = 8;
  localparam int M   = 8;
  localparam int N   = 8;
  localparam int P   = 8;
  localparam int CNT = 64;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              busy;
  logic              mm_start;
  logic              mm_done;
  logic [M*N*DW-1:0] mm_matrix_a;
  logic [N*P*DW-1:0] mm_matrix_b;
  logic [M*P*DW-1:0] mm_result_c;
`ifdef MM_HOST_LAST_EN
  logic              out_last;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            total;
  int            bad;
  int            outs_seen;
  int            rdy_mode;
  int            rdy_phase;
  int            spur_req;
  int            spur_ack;
  int            base;
  int            hold_cnt;
  int            hold_n;
  bit            stalled;
  logic [DW-1:0] held;
  logic [DW-1:0] va[CNT];
  logic [DW-1:0] vb[CNT];
  logic [DW-1:0] vc[CNT];

  mm_host_sequencer #(
    .DATA_WIDTH (DW),
    .M          (M),
    .N          (N),
    .P          (P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .mm_start    (mm_start),
    .mm_done     (mm_done),
    .mm_matrix_a (mm_matrix_a),
    .mm_matrix_b (mm_matrix_b),
    .mm_result_c (mm_result_c)
`ifdef MM_HOST_LAST_EN
    ,
    .out_last    (out_last)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name, input string why);
    total++;
    bad++;
    $display("[TB] FAIL %s: %s at %0t", name, why, $time);
  endtask

  function automatic logic [M*P*DW-1:0] matmul(input logic [M*N*DW-1:0] a,
                                               input logic [N*P*DW-1:0] b);
    logic [M*P*DW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < P; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(a[(i*N+k)*DW +: DW]) * int'(b[(k*P+j)*DW +: DW]);
        r[(i*P+j)*DW +: DW] = s[DW-1:0];
      end
    end
    return r;
  endfunction

  // Behavioural multiplier: garbage result until done, done one cycle, plus stray done pulses.
  initial begin
    mm_done     = 1'b0;
    mm_result_c = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mm_start) begin
        mm_result_c = {(M*P){8'hA5}};
        repeat (4) @(posedge clk);
        #1;
        mm_result_c = matmul(mm_matrix_a, mm_matrix_b);
        mm_done     = 1'b1;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
      end else if (spur_req != spur_ack) begin
        spur_ack    = spur_req;
        mm_result_c = {(M*P){8'h3C}};
        mm_done     = 1'b1;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        out_ready = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 3;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops one expectation per output handshake, and watches stalled data.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall_valid", out_valid, 1);
          checkOutput("stall_data", out_data, held);
        end
        if (out_valid && out_ready) begin
          stalled = 1'b0;
          outs_seen++;
          if (exp_q.size() == 0) begin
            failNow("unexpected_out", "output with empty scoreboard");
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("c_data", out_data, mon_e.data);
`ifdef MM_HOST_LAST_EN
            checkOutput("c_last", out_last, mon_e.last);
`endif
          end
        end else if (out_valid) begin
          stalled = 1'b1;
          held    = out_data;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] data, input int gap);
    int  n;
    bit  ok;
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = data;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) failNow("in_accept", "element never accepted");
    in_valid = 1'b0;
  endtask

  task automatic loadRun(input int gap_max);
    exp_t e;
    for (int k = 0; k < CNT; k++) begin
      e.data = vc[k];
      e.last = (k == CNT - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < CNT; k++) applyStimulus(va[k], int'($urandom_range(gap_max, 0)));
    for (int k = 0; k < CNT; k++) applyStimulus(vb[k], int'($urandom_range(gap_max, 0)));
    checkOutput("start_rise", mm_start, 1);
    checkOutput("start_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("start_width", mm_start, 0);
    checkOutput("wait_in_ready", in_ready, 0);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 3000);
    if (exp_q.size() != 0) failNow(name, "drain did not complete");
    #1;
    checkOutput("post_drain_valid", out_valid, 0);
    checkOutput("post_drain_in_ready", in_ready, 1);
    checkOutput("post_drain_busy", busy, 0);
  endtask

  task automatic setDiagA(input logic [DW-1:0] d);
    for (int k = 0; k < CNT; k++) va[k] = ((k / N) == (k % N)) ? d : '0;
  endtask

  initial begin
    #1_000_000;
    failNow("watchdog", "simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mm_start", mm_start, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_operand_a", |mm_matrix_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_in_ready", in_ready, 1);

    // Identity A, B = 0..63
    setDiagA(8'd1);
    for (int k = 0; k < CNT; k++) begin vb[k] = DW'(k); vc[k] = DW'(k); end
    loadRun(0);
    waitDrain("identity");

    // Saturation: 8 * 0x7F * 0x7F mod 256 = 0x08
    for (int k = 0; k < CNT; k++) begin va[k] = 8'h7F; vb[k] = 8'h7F; vc[k] = 8'h08; end
    loadRun(0);
    waitDrain("saturation");

    // Backpressure: sink ready one cycle in three
    rdy_mode = 1;
    setDiagA(8'd1);
    for (int k = 0; k < CNT; k++) begin vb[k] = DW'(k + 100); vc[k] = DW'(k + 100); end
    loadRun(0);
    waitDrain("backpressure");
    rdy_mode = 0;

    // Stray done while idle, input gaps, in_valid held through WAIT/DRAIN
    spur_req++;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stray_done_busy", busy, 0);
    checkOutput("stray_done_valid", out_valid, 0);
    setDiagA(8'd1);
    for (int k = 0; k < CNT; k++) begin vb[k] = DW'(k) ^ 8'h55; vc[k] = DW'(k) ^ 8'h55; end
    loadRun(3);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    hold_cnt = 0;
    hold_n   = 0;
    while (hold_cnt < CNT && hold_n < 3000) begin
      @(negedge clk);
      hold_n++;
      checkOutput("held_in_ready", in_ready, 0);
      if (out_valid && out_ready) hold_cnt++;
      if (hold_cnt == CNT) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    waitDrain("input_gaps");

    // Reset after 10 drained outputs, then a clean identity run
    setDiagA(8'd1);
    for (int k = 0; k < CNT; k++) begin vb[k] = DW'(k); vc[k] = DW'(k); end
    base = outs_seen;
    loadRun(0);
    hold_n = 0;
    while (outs_seen < base + 10 && hold_n < 3000) begin
      @(posedge clk);
      hold_n++;
    end
    if (outs_seen < base + 10) failNow("abort_wait", "outputs did not start");
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_operand_a", |mm_matrix_a, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    loadRun(0);
    waitDrain("after_abort");

    // Back-to-back: identity, then A = 2*I with B = 63-k
    loadRun(0);
    setDiagA(8'd2);
    for (int k = 0; k < CNT; k++) begin vb[k] = DW'(63 - k); vc[k] = DW'(2 * (63 - k)); end
    loadRun(0);
    waitDrain("back_to_back");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
